data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the load/store unit's data memory interface.
- Accepts byte-addressed read and write requests and holds a word-organised memory array.
- Applies byte-lane write strobes and returns read data with a fixed one-cycle latency.
- After reset it runs a sequential clear of the whole array and signals busy until the clear completes; the load/store unit stalls on busy.

Parameters:
- ADDR_WIDTH, 12, byte-address width; the array holds 2**(ADDR_WIDTH-2) words.
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear and be ready one cycle after reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- memory_read_enable  input  1  read request this cycle.
- memory_read_address  input  ADDR_WIDTH  byte address of read; bits [1:0] ignored.
- memory_read_data  output  DATA_WIDTH  registered read word.
- memory_read_valid  output  1  memory_read_data holds the response to the previous cycle's accepted read.
- memory_write_enable  input  1  write request this cycle.
- memory_write_address  input  ADDR_WIDTH  byte address of write; bits [1:0] ignored.
- memory_write_data  input  DATA_WIDTH  write word, lane-aligned by the initiator.
- memory_write_strobe  input  4  byte-lane enables; bit i writes bits [8i+7:8i].
- memory_busy  output  1  clear in progress; requests are not accepted.
- clear_done  output  1  one-cycle pulse on the cycle the FSM enters READY.

Behaviour:
- Reset is one clock, clk, with rst synchronous and active-high. With rst high at a rising edge: memory_read_data=0, memory_read_valid=0, clear_done=0, clear index=0. The FSM goes to CLEAR if CLEAR_ON_RESET=1, else to READY. memory_busy is 1 while rst is high.
- FSM states:
  - CLEAR: each cycle writes 0 to word[clear index], then increments the index. busy=1. Read and write requests are ignored: no array update, no valid. On the cycle the last word is written (index = 2**(ADDR_WIDTH-2)-1), the next state is READY, clear_done pulses for 1 cycle on entering READY, and the index wraps to 0.
  - READY: busy=0. Accepts requests every cycle. Remains in READY until rst.
- CLEAR takes exactly 2**(ADDR_WIDTH-2) cycles after reset deassertion. With CLEAR_ON_RESET=0: the first cycle after reset is READY, clear_done pulses once, and array contents are undefined.
- Reset asserted mid-CLEAR: the clear restarts from index 0. Reset asserted in READY: the clear runs again and the array is zeroed.
- Write (READY, write_enable=1): word index = write_address[ADDR_WIDTH-1:2]. Only lanes with strobe=1 update at the rising edge. strobe=0000 with enable=1 is a legal no-op.
- Read (READY, read_enable=1): word index = read_address[ADDR_WIDTH-1:2]. On the next cycle memory_read_data = word contents and memory_read_valid = 1, so latency is 1 cycle.
- Cycle with read_enable=0 in READY: valid=0 next cycle; read_data holds its last value and is not cleared.
- Same-cycle read and write to the same word: write-first. Returned data is the old word merged with the new lanes selected by strobe. Different words: independent, both complete.
- Back-to-back reads give one response per cycle, in order, with no bubbles.
- Sign/zero extension and lane shifting for lb/lh/lbu/lhu are the initiator's job. This block returns the full word.

Test Plan:
- Use ADDR_WIDTH=6 (16 words), CLEAR_ON_RESET=1, and hold rst high for 2 cycles, then low. Required response: busy=1 for exactly 16 cycles, clear_done pulses on cycle 17, then read addr 0x3C returns 0x00000000 with valid one cycle later.
- In READY, write addr 0x08 with data 0xDEADBEEF, strobe 1111, then write addr 0x0A with data 0x00AA0000, strobe 0100, then read 0x08. Required response: read_data=0xDEAABEEF, valid=1.
- Same-cycle write and read to addr 0x10: existing word 0x11223344, write data 0x00000099, strobe 0001. Required response: next cycle read_data=0x11223399.
- Issue reads of 0x00, 0x04, 0x08 on consecutive cycles after writing 1, 2, 3 to those addresses. Required response: read_data 1, 2, 3 on consecutive cycles with valid continuously 1, then valid=0 on the following cycle with data held at 3.
- Assert rst at clear index 7, then issue write/read requests during CLEAR. Required response: the clear restarts with 16 full busy cycles, requests during busy leave no effect, and valid stays 0.
- With CLEAR_ON_RESET=0, reset then write 0x12345678 to addr 0x04 in the first post-reset cycle. Required response: busy=0 immediately, clear_done pulses once, and reading addr 0x04 returns 0x12345678.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data memory responder: word-organised array with byte-lane writes, one-cycle
// registered reads, and a sequential zero-clear of the array after reset.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memory_read_enable,
  input  logic [ADDR_WIDTH-1:0] memory_read_address,
  output logic [DATA_WIDTH-1:0] memory_read_data,
  output logic                  memory_read_valid,
  input  logic                  memory_write_enable,
  input  logic [ADDR_WIDTH-1:0] memory_write_address,
  input  logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [3:0]            memory_write_strobe,
  output logic                  memory_busy,
  output logic                  clear_done
);

  localparam int unsigned INDEX_WIDTH = ADDR_WIDTH - 2;
  localparam int unsigned WORDS       = 2 ** INDEX_WIDTH;
  localparam int unsigned LANES       = DATA_WIDTH / 8;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [INDEX_WIDTH-1:0]  clear_index;
  logic [INDEX_WIDTH-1:0]  clear_index_next;
  logic                    clear_done_next;
  logic                    read_accept;
  logic                    rst_q;

  logic                    array_write;
  logic [INDEX_WIDTH-1:0]  array_index;
  logic [DATA_WIDTH-1:0]   array_data;
  logic [LANES-1:0]        array_strobe;
  logic [DATA_WIDTH-1:0]   merged_read;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic [INDEX_WIDTH-1:0]  read_index;
  logic [INDEX_WIDTH-1:0]  write_index;
  logic                    unused_address_bits;

  assign read_index          = memory_read_address[ADDR_WIDTH-1:2];
  assign write_index         = memory_write_address[ADDR_WIDTH-1:2];
  assign unused_address_bits = ^{memory_read_address[1:0], memory_write_address[1:0]};

  // Busy covers the reset cycles themselves as well as the clear sweep.
  assign memory_busy = rst || (state == CLEAR);

  // Next-state, clear sweep and array-port selection.
  always_comb begin
    state_next       = state;
    clear_index_next = clear_index;
    clear_done_next  = 1'b0;
    read_accept      = 1'b0;
    array_write      = 1'b0;
    array_index      = write_index;
    array_data       = memory_write_data;
    array_strobe     = LANES'(memory_write_strobe);
    case (state)
      CLEAR: begin
        array_write      = 1'b1;
        array_index      = clear_index;
        array_data       = '0;
        array_strobe     = '1;
        clear_index_next = INDEX_WIDTH'(clear_index + 1'b1);
        if (clear_index == INDEX_WIDTH'(WORDS - 1)) begin
          state_next      = READY;
          clear_done_next = 1'b1;
        end
      end
      READY: begin
        array_write = memory_write_enable;
        read_accept = memory_read_enable;
      end
      default: state_next = READY;
    endcase
    // Without a clear, READY is entered by reset itself; announce it once reset drops.
    if (!CLEAR_ON_RESET && rst_q) clear_done_next = 1'b1;
  end

  // Write-first: a same-word write in this cycle is visible to the read.
  always_comb begin
    merged_read = mem[read_index];
    if (state == READY && memory_write_enable && write_index == read_index) begin
      for (int i = 0; i < LANES; i++) begin
        if (memory_write_strobe[i]) merged_read[8*i +: 8] = memory_write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state             <= CLEAR_ON_RESET ? CLEAR : READY;
      clear_index       <= '0;
      clear_done        <= 1'b0;
      memory_read_data  <= '0;
      memory_read_valid <= 1'b0;
    end else begin
      state             <= state_next;
      clear_index       <= clear_index_next;
      clear_done        <= clear_done_next;
      memory_read_valid <= read_accept;
      if (read_accept) memory_read_data <= merged_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && array_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (array_strobe[i]) mem[array_index][8*i +: 8] <= array_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus random traffic
// checked against a word-array reference model.
module tb_data_memory_responder;

  localparam int unsigned AW    = 6;
  localparam int unsigned WORDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [5:0]  ra, wa;
  logic [31:0] wd;
  logic [3:0]  ws;
  logic [31:0] rd;
  logic        rv, busy, done;

  logic        rst0;
  logic        re0, we0;
  logic [5:0]  ra0, wa0;
  logic [31:0] wd0;
  logic [3:0]  ws0;
  logic [31:0] rd0;
  logic        rv0, busy0, done0;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [WORDS];
  logic [31:0] exp_data;
  logic        exp_valid;
  logic        exp_done;
  int          clear_left;

  data_memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .memory_read_enable(re), .memory_read_address(ra),
    .memory_read_data(rd), .memory_read_valid(rv),
    .memory_write_enable(we), .memory_write_address(wa),
    .memory_write_data(wd), .memory_write_strobe(ws),
    .memory_busy(busy), .clear_done(done)
  );

  data_memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst(rst0),
    .memory_read_enable(re0), .memory_read_address(ra0),
    .memory_read_data(rd0), .memory_read_valid(rv0),
    .memory_write_enable(we0), .memory_write_address(wa0),
    .memory_write_data(wd0), .memory_write_strobe(ws0),
    .memory_busy(busy0), .clear_done(done0)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r_en, input logic [5:0] r_addr, input logic w_en,
                       input logic [5:0] w_addr, input logic [31:0] w_data, input logic [3:0] w_strb);
    re = r_en; ra = r_addr; we = w_en; wa = w_addr; wd = w_data; ws = w_strb;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 4'd0);
  endtask

  task automatic drive_random();
    drive(1'($urandom), 6'($urandom_range(0, 63)), 1'($urandom), 6'($urandom_range(0, 63)),
          $urandom, 4'($urandom));
  endtask

  // One clock edge: advance the reference model by the rules, then settle past the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      clear_left = WORDS;
      exp_data   = 32'd0;
      exp_valid  = 1'b0;
      exp_done   = 1'b0;
      for (int i = 0; i < WORDS; i++) model_mem[i] = 32'd0;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_valid = 1'b0;
      exp_done  = (clear_left == 0);
    end else begin
      exp_done = 1'b0;
      if (we) begin
        for (int l = 0; l < 4; l++)
          if (ws[l]) model_mem[wa / 4][8*l +: 8] = wd[8*l +: 8];
      end
      if (re) exp_data = model_mem[ra / 4];
      exp_valid = re;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (busy !== 1'b1 || rv !== 1'b0 || rd !== 32'd0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: busy=%b valid=%b data=%h done=%b, want 1 0 00000000 0", busy, rv, rd, done);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL clear_busy cycle %0d: busy=%b done=%b, want 1 0", k, busy, done);
      end
      cycle();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL clear_done_pulse: busy=%b done=%b, want 0 1", busy, done);
    end
    drive(1'b1, 6'h3C, 1'b0, 6'd0, 32'd0, 4'd0);
    cycle();
    idle();
    checks++;
    if (rv !== 1'b1 || rd !== 32'h0000_0000 || done !== 1'b0) begin
      errors++;
      $display("FAIL read_after_clear: valid=%b data=%h done=%b, want 1 00000000 0", rv, rd, done);
    end
  endtask

  task automatic test_strobe_merge();
    drive(1'b0, 6'd0, 1'b1, 6'h08, 32'hDEAD_BEEF, 4'b1111);
    cycle();
    drive(1'b0, 6'd0, 1'b1, 6'h0A, 32'h00AA_0000, 4'b0100);
    cycle();
    drive(1'b1, 6'h08, 1'b0, 6'd0, 32'd0, 4'd0);
    cycle();
    idle();
    checks++;
    if (rv !== 1'b1 || rd !== 32'hDEAA_BEEF) begin
      errors++;
      $display("FAIL strobe_merge: valid=%b data=%h, want 1 deaabeef", rv, rd);
    end
  endtask

  task automatic test_write_first();
    drive(1'b0, 6'd0, 1'b1, 6'h10, 32'h1122_3344, 4'b1111);
    cycle();
    drive(1'b1, 6'h10, 1'b1, 6'h10, 32'h0000_0099, 4'b0001);
    cycle();
    checks++;
    if (rv !== 1'b1 || rd !== 32'h1122_3399) begin
      errors++;
      $display("FAIL write_first: valid=%b data=%h, want 1 11223399", rv, rd);
    end
    drive(1'b1, 6'h12, 1'b0, 6'd0, 32'd0, 4'd0);
    cycle();
    idle();
    checks++;
    if (rv !== 1'b1 || rd !== 32'h1122_3399) begin
      errors++;
      $display("FAIL write_first_stored: valid=%b data=%h, want 1 11223399", rv, rd);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 6'd0, 1'b1, 6'(4 * k), 32'(k + 1), 4'b1111);
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 6'(4 * k), 1'b0, 6'd0, 32'd0, 4'd0);
      cycle();
      checks++;
      if (rv !== 1'b1 || rd !== 32'(k + 1)) begin
        errors++;
        $display("FAIL back_to_back read %0d: valid=%b data=%h, want 1 %h", k, rv, rd, 32'(k + 1));
      end
    end
    idle();
    cycle();
    checks++;
    if (rv !== 1'b0 || rd !== 32'd3) begin
      errors++;
      $display("FAIL back_to_back_hold: valid=%b data=%h, want 0 00000003", rv, rd);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive_random();
      cycle();
      checks++;
      if (rv !== exp_valid || rd !== exp_data || busy !== 1'b0) begin
        errors++;
        $display("FAIL random cycle %0d: valid=%b data=%h busy=%b, want %b %h 0", n, rv, rd, busy, exp_valid, exp_data);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive_random();
      cycle();
      checks++;
      if (busy !== 1'b1 || rv !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL partial_clear cycle %0d: busy=%b valid=%b done=%b, want 1 0 0", k, busy, rv, done);
      end
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      checks++;
      if (busy !== 1'b1 || rv !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL restart_clear cycle %0d: busy=%b valid=%b done=%b, want 1 0 0", k, busy, rv, done);
      end
      drive_random();
      cycle();
    end
    idle();
    checks++;
    if (busy !== 1'b0 || done !== exp_done || done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: busy=%b done=%b, want 0 1", busy, done);
    end
    for (int k = 0; k < WORDS; k++) begin
      drive(1'b1, 6'(4 * k), 1'b0, 6'd0, 32'd0, 4'd0);
      cycle();
      checks++;
      if (rv !== 1'b1 || rd !== exp_data || rd !== 32'd0) begin
        errors++;
        $display("FAIL zeroed_word %0d: valid=%b data=%h, want 1 00000000", k, rv, rd);
      end
    end
    idle();
  endtask

  task automatic test_no_clear();
    int pulses;
    rst0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL noclear_in_reset: busy=%b done=%b, want 1 0", busy0, done0);
    end
    rst0 = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL noclear_busy: busy=%b, want 0", busy0);
    end
    we0 = 1'b1; wa0 = 6'h04; wd0 = 32'h1234_5678; ws0 = 4'b1111;
    pulses = 0;
    @(posedge clk); #1;
    if (done0 === 1'b1) pulses++;
    we0 = 1'b0; re0 = 1'b1; ra0 = 6'h04;
    @(posedge clk); #1;
    if (done0 === 1'b1) pulses++;
    re0 = 1'b0;
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL noclear_read: valid=%b data=%h, want 1 12345678", rv0, rd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL noclear_done_pulses: pulses=%0d busy=%b, want 1 0", pulses, busy0);
    end
  endtask

  initial begin
    rst0 = 1'b1; re0 = 1'b0; we0 = 1'b0; ra0 = '0; wa0 = '0; wd0 = '0; ws0 = '0;
    rst = 1'b1;
    idle();
    exp_data = '0; exp_valid = 1'b0; exp_done = 1'b0; clear_left = WORDS;
    test_reset();
    test_strobe_merge();
    test_write_first();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    test_no_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
